// File: rtl/fdtd_buf_pkg.sv
// Shared types and helpers for the FDTD field line buffer.
// The optional dropped-beat counter is enabled with FDTD_BUF_DROP_CNT_EN.
package fdtd_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_LOADED = 3'd2,
        ST_PRIME  = 3'd3,
        ST_STREAM = 3'd4
    } buf_state_e;

    // Value presented as x[i+1] past the last sample (PEC wall).
    localparam int unsigned BOUNDARY_VALUE = 0;

    // Requested pass length limited to what the buffer can hold.
    function automatic int unsigned clamp_size(input int unsigned req, input int unsigned depth);
        return (req > depth) ? depth : req;
    endfunction

endpackage

// File: rtl/fdtd_buf_ram.sv
// Simple dual-port RAM, synchronous read with one cycle of latency.
// Written so synthesis maps it onto a block RAM.
module fdtd_buf_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port and registered read port; read data holds when rd_en is low.
    // NOTE: storage arrays have no reset -- a reset would stop block-RAM mapping,
    // and the contents are don't-care until the next fill anyway.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fdtd_field_buf.sv
// FDTD field line buffer: captures one field vector from AXI read beats and
// replays it as neighbour pairs (x[i], x[i+1]) with x[size] = 0.
// Optional FDTD_BUF_DROP_CNT_EN adds drop_cnt_o, a saturating dropped-beat count.
module fdtd_field_buf
    import fdtd_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [CNT_W-1:0]      buffer_size_i,
    input  logic                  fill_start_i,
    input  logic                  fill_valid_i,
    input  logic [DATA_WIDTH-1:0] fill_data_i,
    output logic                  fill_done_o,
    input  logic                  strm_start_i,
    output logic                  strm_valid_o,
    input  logic                  strm_ready_i,
    output logic [DATA_WIDTH-1:0] strm_cur_o,
    output logic [DATA_WIDTH-1:0] strm_nxt_o,
    output logic                  strm_last_o,
    output logic                  strm_done_o,
    output logic                  busy_o,
    output logic                  err_o
`ifdef FDTD_BUF_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] BOUNDARY = DATA_WIDTH'(BOUNDARY_VALUE);

    buf_state_e            state_q, state_d;
    logic [CNT_W-1:0]      size_q, size_d;
    logic [CNT_W-1:0]      wptr_q, wptr_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic                  fill_done_q, fill_done_d;
    logic                  strm_done_q, strm_done_d;
    logic                  err_q, err_d;

    logic                  wr_en, rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [CNT_W-1:0]      size_clamped, wptr_inc, idx_p2;
    logic                  is_last, beat_dropped;

    assign size_clamped = CNT_W'(clamp_size(32'(buffer_size_i), 32'(DEPTH)));
    assign wptr_inc     = wptr_q + CNT_W'(1);
    assign idx_p2       = idx_q + CNT_W'(2);
    assign is_last      = (idx_q == size_q - CNT_W'(1));
    assign beat_dropped = fill_valid_i && !fill_start_i &&
                          !((state_q == ST_FILL) && (wptr_q < size_q));

    fdtd_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk       (ACLK),
        .wr_en     (wr_en),
        .wr_addr   (wptr_q[AW-1:0]),
        .wr_data   (fill_data_i),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data_o (ram_rdata)
    );

    // Next-state, RAM port control and pulse generation for fill and stream.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        size_d      = size_q;
        wptr_d      = wptr_q;
        idx_d       = idx_q;
        cur_d       = cur_q;
        err_d       = err_q;
        fill_done_d = 1'b0;
        strm_done_d = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;

        if (fill_start_i) begin
            // A new pass wins over everything, including an active stream.
            size_d      = size_clamped;
            wptr_d      = '0;
            idx_d       = '0;
            err_d       = (buffer_size_i > DEPTH_C);
            fill_done_d = (size_clamped == '0);
            state_d     = (size_clamped == '0) ? ST_LOADED : ST_FILL;
        end else begin
            if (beat_dropped) begin
                err_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (strm_start_i) err_d = 1'b1;
                end
                ST_FILL: begin
                    if (strm_start_i) err_d = 1'b1;
                    if (fill_valid_i && (wptr_q < size_q)) begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_inc;
                        if (wptr_inc == size_q) begin
                            fill_done_d = 1'b1;
                            state_d     = ST_LOADED;
                        end
                    end
                end
                ST_LOADED: begin
                    if (strm_start_i) begin
                        idx_d = '0;
                        if (size_q == '0) begin
                            strm_done_d = 1'b1;
                        end else begin
                            rd_en   = 1'b1;           // fetch x[0]
                            state_d = ST_PRIME;
                        end
                    end
                end
                ST_PRIME: begin
                    cur_d   = ram_rdata;              // x[0] arrives now
                    rd_en   = (size_q > CNT_W'(1));   // fetch x[1] if it exists
                    rd_addr = AW'(1);
                    state_d = ST_STREAM;
                end
                ST_STREAM: begin
                    if (strm_ready_i) begin
                        if (is_last) begin
                            strm_done_d = 1'b1;
                            state_d     = ST_LOADED;
                        end else begin
                            cur_d   = ram_rdata;      // old x[i+1] becomes x[i]
                            idx_d   = idx_q + CNT_W'(1);
                            rd_en   = (idx_p2 < size_q);
                            rd_addr = idx_p2[AW-1:0];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control and pipeline registers, cleared asynchronously.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            size_q      <= '0;
            wptr_q      <= '0;
            idx_q       <= '0;
            cur_q       <= '0;
            fill_done_q <= 1'b0;
            strm_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            wptr_q      <= wptr_d;
            idx_q       <= idx_d;
            cur_q       <= cur_d;
            fill_done_q <= fill_done_d;
            strm_done_q <= strm_done_d;
            err_q       <= err_d;
        end
    end

`ifdef FDTD_BUF_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of beats that arrived when they could not be stored.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (fill_start_i) begin
            drop_cnt_d = '0;
        end else if (beat_dropped && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Dropped-beat counter register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign strm_valid_o = (state_q == ST_STREAM);
    assign strm_cur_o   = strm_valid_o ? cur_q : '0;
    assign strm_nxt_o   = (strm_valid_o && !is_last) ? ram_rdata : BOUNDARY;
    assign strm_last_o  = strm_valid_o && is_last;
    assign fill_done_o  = fill_done_q;
    assign strm_done_o  = strm_done_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_fdtd_field_buf.sv
// Self-checking bench for fdtd_field_buf: a queue-based model of the captured
// vector produces the expected neighbour pairs, and one monitor compares every
// valid cycle against it. Honours FDTD_BUF_DROP_CNT_EN for drop_cnt_o.
module tb_fdtd_field_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [DW-1:0] cur;
        logic [DW-1:0] nxt;
        logic          last;
    } pair_t;

    logic             ACLK;
    logic             ARESETn;
    logic [CNT_W-1:0] buffer_size_i;
    logic             fill_start_i;
    logic             fill_valid_i;
    logic [DW-1:0]    fill_data_i;
    logic             fill_done_o;
    logic             strm_start_i;
    logic             strm_valid_o;
    logic             strm_ready_i;
    logic [DW-1:0]    strm_cur_o;
    logic [DW-1:0]    strm_nxt_o;
    logic             strm_last_o;
    logic             strm_done_o;
    logic             busy_o;
    logic             err_o;
`ifdef FDTD_BUF_DROP_CNT_EN
    logic [7:0]       drop_cnt_o;
`endif

    fdtd_field_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .buffer_size_i (buffer_size_i),
        .fill_start_i  (fill_start_i),
        .fill_valid_i  (fill_valid_i),
        .fill_data_i   (fill_data_i),
        .fill_done_o   (fill_done_o),
        .strm_start_i  (strm_start_i),
        .strm_valid_o  (strm_valid_o),
        .strm_ready_i  (strm_ready_i),
        .strm_cur_o    (strm_cur_o),
        .strm_nxt_o    (strm_nxt_o),
        .strm_last_o   (strm_last_o),
        .strm_done_o   (strm_done_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
`ifdef FDTD_BUF_DROP_CNT_EN
        ,
        .drop_cnt_o    (drop_cnt_o)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] model_mem [$];     // what the buffer should hold
    pair_t         exp_q [$];         // pairs still to be accepted
    int            acc_cnt      = 0;  // pairs accepted in the current stream
    int            exp_done_cyc = -1; // cycle in which strm_done_o must be high
    logic [DW-1:0] obs_cur [DEPTH];
    logic [DW-1:0] obs_nxt [DEPTH];

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Compare process: every valid pair must equal the head of the expected queue.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (strm_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(strm_valid_o), 64'd0);
                end else begin
                    check("pair_cur", 64'(strm_cur_o), 64'(exp_q[0].cur));
                    check("pair_nxt", 64'(strm_nxt_o), 64'(exp_q[0].nxt));
                    check("pair_last", 64'(strm_last_o), 64'(exp_q[0].last));
                    if (strm_ready_i) begin
                        if (acc_cnt < DEPTH) begin
                            obs_cur[acc_cnt] = strm_cur_o;
                            obs_nxt[acc_cnt] = strm_nxt_o;
                        end
                        if (exp_q[0].last) exp_done_cyc = cyc + 1;
                        void'(exp_q.pop_front());
                        acc_cnt++;
                    end
                end
            end
            if (strm_done_o) check("strm_done_cycle", 64'(cyc), 64'(exp_done_cyc));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_fill_done"}, 64'(fill_done_o), 64'd0);
        check({tag, "_valid"}, 64'(strm_valid_o), 64'd0);
        check({tag, "_cur"}, 64'(strm_cur_o), 64'd0);
        check({tag, "_nxt"}, 64'(strm_nxt_o), 64'd0);
        check({tag, "_last"}, 64'(strm_last_o), 64'd0);
        check({tag, "_strm_done"}, 64'(strm_done_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
`ifdef FDTD_BUF_DROP_CNT_EN
        check({tag, "_drop_cnt"}, 64'(drop_cnt_o), 64'd0);
`endif
    endtask

    // Start a pass of sz samples; data_mode 0 gives 1,2,3..., else random.
    task automatic do_fill(input int sz, input bit rand_data, input bit gaps);
        int            eff;
        logic [DW-1:0] d;
        eff = (sz > DEPTH) ? DEPTH : sz;
        buffer_size_i = CNT_W'(sz);
        fill_start_i  = 1'b1;
        tick();
        fill_start_i  = 1'b0;
        exp_q.delete();
        exp_done_cyc  = -1;
        model_mem.delete();
        check("fill_err", 64'(err_o), 64'(sz > DEPTH));
        check("fill_valid_low", 64'(strm_valid_o), 64'd0);
        check("fill_busy", 64'(busy_o), 64'd1);
`ifdef FDTD_BUF_DROP_CNT_EN
        check("fill_drop_clr", 64'(drop_cnt_o), 64'd0);
`endif
        if (eff == 0) begin
            check("fill_done_size0", 64'(fill_done_o), 64'd1);
            tick();
            check("fill_done_size0_pulse", 64'(fill_done_o), 64'd0);
            return;
        end
        for (int i = 0; i < eff; i++) begin
            while (gaps && ($urandom_range(0, 3) == 0)) begin
                fill_valid_i = 1'b0;
                tick();
                check("fill_done_gap", 64'(fill_done_o), 64'd0);
            end
            d = rand_data ? DW'($urandom) : DW'(i + 1);
            fill_valid_i = 1'b1;
            fill_data_i  = d;
            model_mem.push_back(d);
            tick();
            check((i == eff - 1) ? "fill_done" : "fill_done_early",
                  64'(fill_done_o), 64'(i == eff - 1));
        end
        fill_valid_i = 1'b0;
        tick();
        check("fill_done_pulse", 64'(fill_done_o), 64'd0);
        check("fill_err_hold", 64'(err_o), 64'(sz > DEPTH));
    endtask

    function automatic bit ready_val(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Stream the loaded vector; mode 0 ready high, 1 toggling, 2 random.
    // With abort_after >= 0, return mid-stream once that many pairs are taken.
    task automatic do_stream(input int mode, input int abort_after);
        int    eff;
        int    k;
        bit    done_seen;
        pair_t p;
        eff = model_mem.size();
        for (int i = 0; i < eff; i++) begin
            p.cur  = model_mem[i];
            p.nxt  = (i == eff - 1) ? '0 : model_mem[i + 1];
            p.last = (i == eff - 1);
            exp_q.push_back(p);
        end
        acc_cnt      = 0;
        strm_start_i = 1'b1;
        strm_ready_i = ready_val(mode, 0);
        if (eff == 0) exp_done_cyc = cyc + 1;
        tick();
        strm_start_i = 1'b0;
        if (eff == 0) begin
            check("strm_done_size0", 64'(strm_done_o), 64'd1);
            check("strm_valid_size0", 64'(strm_valid_o), 64'd0);
            tick();
            check("strm_done_size0_pulse", 64'(strm_done_o), 64'd0);
            check("strm_valid_size0_after", 64'(strm_valid_o), 64'd0);
            return;
        end
        check("prime_valid_low", 64'(strm_valid_o), 64'd0);
        tick();
        check("first_valid_2cyc", 64'(strm_valid_o), 64'd1);
        k = 0;
        done_seen = 1'b0;
        while (k < 4 * eff + 50) begin
            if ((abort_after >= 0) && (acc_cnt == abort_after)) begin
                strm_ready_i = 1'b0;
                return;
            end
            strm_ready_i = ready_val(mode, k);
            k++;
            tick();
            if (strm_done_o) begin
                done_seen = 1'b1;
                break;
            end
        end
        strm_ready_i = 1'b0;
        check("strm_done_seen", 64'(done_seen), 64'd1);
        check("strm_pairs_left", 64'(exp_q.size()), 64'd0);
        check("strm_pairs_taken", 64'(acc_cnt), 64'(eff));
        tick();
        check("strm_done_pulse", 64'(strm_done_o), 64'd0);
        check("strm_loaded_busy", 64'(busy_o), 64'd1);
        check("strm_valid_after", 64'(strm_valid_o), 64'd0);
    endtask

    initial begin
        ARESETn       = 1'b1;
        buffer_size_i = '0;
        fill_start_i  = 1'b0;
        fill_valid_i  = 1'b0;
        fill_data_i   = '0;
        strm_start_i  = 1'b0;
        strm_ready_i  = 1'b0;
        #1 ARESETn = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        ARESETn = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Stream request with nothing loaded is an error and is ignored.
        strm_start_i = 1'b1;
        tick();
        strm_start_i = 1'b0;
        check("idle_strm_err", 64'(err_o), 64'd1);
        check("idle_strm_busy", 64'(busy_o), 64'd0);
        tick();
        check("idle_strm_novalid", 64'(strm_valid_o), 64'd0);

        // size 8, data 1..8, ready held high; pin the observed pairs.
        do_fill(8, 1'b0, 1'b0);
        do_stream(0, -1);
        check("pin_cur0", 64'(obs_cur[0]), 64'd1);
        check("pin_nxt0", 64'(obs_nxt[0]), 64'd2);
        check("pin_nxt6", 64'(obs_nxt[6]), 64'd8);
        check("pin_cur7", 64'(obs_cur[7]), 64'd8);
        check("pin_nxt7", 64'(obs_nxt[7]), 64'd0);

        // Replay of the same contents with random back-pressure.
        do_stream(2, -1);
        check("pin_replay_cur7", 64'(obs_cur[7]), 64'd8);

        // size 4, ready toggling.
        do_fill(4, 1'b1, 1'b0);
        do_stream(1, -1);

        // Oversized request is clamped to DEPTH and flagged.
        do_fill(300, 1'b1, 1'b1);
        do_stream(0, -1);
        check("clamp_pairs", 64'(acc_cnt), 64'd256);
        check("clamp_err_sticky", 64'(err_o), 64'd1);

        // Empty pass.
        do_fill(0, 1'b1, 1'b0);
        do_stream(0, -1);

        // Abort at pair 3 of 8 by a new fill, then stream the new data.
        do_fill(8, 1'b1, 1'b0);
        do_stream(0, 3);
        check("abort_at_pair3", 64'(acc_cnt), 64'd3);
        do_fill(8, 1'b1, 1'b0);
        do_stream(0, -1);

        // Random sizes, gaps and back-pressure.
        for (int r = 0; r < 6; r++) begin
            do_fill($urandom_range(1, 20), 1'b1, 1'b1);
            do_stream(2, -1);
        end

        // Beats while LOADED are dropped and flagged.
        fill_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fill_data_i = DW'($urandom);
            tick();
        end
        fill_valid_i = 1'b0;
        check("loaded_beat_err", 64'(err_o), 64'd1);
`ifdef FDTD_BUF_DROP_CNT_EN
        check("loaded_drop_cnt", 64'(drop_cnt_o), 64'd3);
`endif

        // Partial fill interrupted by reset.
        buffer_size_i = CNT_W'(8);
        fill_start_i  = 1'b1;
        tick();
        fill_start_i  = 1'b0;
        check("refill_err_clr", 64'(err_o), 64'd0);
        fill_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fill_data_i = DW'($urandom);
            tick();
        end
        #2 ARESETn = 1'b0;
        fill_valid_i = 1'b0;
        #1;
        check_all_zero("mid_fill_reset");
        tick();
        ARESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("after_reset_fill_done", 64'(fill_done_o), 64'd0);
        end
        check_all_zero("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
